// File: rtl/removal_pkg.sv
// Shared types and default sizing for the removal-check synchronizer/filter.
package removal_pkg;

  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    QUAL_HIGH = 2'd1,
    ST_HIGH   = 2'd2,
    QUAL_LOW  = 2'd3
  } filt_state_e;

  localparam int SYNC_STAGES_DEF   = 2;
  localparam int FILTER_CYCLES_DEF = 4;
  localparam int CNT_W_DEF         = 8;

endpackage

// File: rtl/sync_chain.sv
// N-flop synchronizer; s[0] is the only flop allowed to go metastable, so the
// gate-level removal/recovery checks are aimed at this instance.
module sync_chain #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] s;

  always_ff @(posedge clk) begin
    if (!rst_n) s <= '0;
    else        s <= {s[N-2:0], d};
  end

  assign q = s[N-1];

endmodule

// File: rtl/removal_sync_filter.sv
// Synchronizes and glitch-filters the removal-check flop output, producing a
// clean level, edge pulses and saturating release/glitch counters.
//
// state     | meaning
// ST_LOW    | level_out=0, waiting for synced=1
// QUAL_HIGH | counting consecutive synced=1 samples toward a rise
// ST_HIGH   | level_out=1, waiting for synced=0
// QUAL_LOW  | counting consecutive synced=0 samples toward a release
module removal_sync_filter
  import removal_pkg::*;
#(
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int FILTER_CYCLES = FILTER_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             async_in,
  input  logic             en,
  input  logic             clr_cnt,
  output logic             level_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] release_cnt,
  output logic [CNT_W-1:0] glitch_cnt
);

  localparam int             QW     = 8;
  localparam logic [QW-1:0]  Q_LAST = QW'(FILTER_CYCLES - 1);

  filt_state_e   state;
  logic [QW-1:0] qcnt;
  logic          synced;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  sync_chain #(.N(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (async_in),
    .q     (synced)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_LOW;
      qcnt        <= '0;
      level_out   <= 1'b0;
      rise_pulse  <= 1'b0;
      fall_pulse  <= 1'b0;
      release_cnt <= '0;
      glitch_cnt  <= '0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      case (state)
        ST_LOW: begin
          if (en && synced) begin
            state <= QUAL_HIGH;
            qcnt  <= QW'(1);
          end
        end
        QUAL_HIGH: begin
          // en is checked first so disabling never registers as a glitch
          if (!en) begin
            state <= ST_LOW;
          end else if (!synced) begin
            state      <= ST_LOW;
            glitch_cnt <= sat_inc(glitch_cnt);
          end else if (qcnt == Q_LAST) begin
            state      <= ST_HIGH;
            level_out  <= 1'b1;
            rise_pulse <= 1'b1;
          end else begin
            qcnt <= qcnt + QW'(1);
          end
        end
        ST_HIGH: begin
          if (en && !synced) begin
            state <= QUAL_LOW;
            qcnt  <= QW'(1);
          end
        end
        QUAL_LOW: begin
          if (!en) begin
            state <= ST_HIGH;
          end else if (synced) begin
            state      <= ST_HIGH;
            glitch_cnt <= sat_inc(glitch_cnt);
          end else if (qcnt == Q_LAST) begin
            state       <= ST_LOW;
            level_out   <= 1'b0;
            fall_pulse  <= 1'b1;
            release_cnt <= sat_inc(release_cnt);
          end else begin
            qcnt <= qcnt + QW'(1);
          end
        end
        default: state <= ST_LOW;
      endcase
      // Placed last so a clear overrides any increment in the same cycle.
      if (clr_cnt) begin
        release_cnt <= '0;
        glitch_cnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_removal_sync_filter.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized stimulus against a run-length reference model.
module tb_removal_sync_filter;
  import removal_pkg::*;

  localparam int SYNC = SYNC_STAGES_DEF;
  localparam int FC   = FILTER_CYCLES_DEF;
  localparam int CW   = CNT_W_DEF;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n, async_in, en, clr_cnt;
  logic          level_out, rise_pulse, fall_pulse;
  logic [CW-1:0] release_cnt, glitch_cnt;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  removal_sync_filter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .async_in    (async_in),
    .en          (en),
    .clr_cnt     (clr_cnt),
    .level_out   (level_out),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .release_cnt (release_cnt),
    .glitch_cnt  (glitch_cnt)
  );

  // Reference model: a plain delay line for synchronization, then a run of
  // consecutive enabled disagreeing samples; a run of FC flips the level.
  bit dq[$];
  bit m_level, m_rise, m_fall;
  int m_run, m_rel, m_gl;

  task automatic model_reset();
    dq.delete();
    repeat (SYNC) dq.push_back(1'b0);
    m_level = 0; m_rise = 0; m_fall = 0;
    m_run = 0; m_rel = 0; m_gl = 0;
  endtask

  task automatic model_step();
    bit synced, inc_rel, inc_gl;
    if (!rst_n) begin
      model_reset();
      return;
    end
    synced = dq.pop_front();
    dq.push_back(async_in === 1'b1);
    m_rise = 0; m_fall = 0; inc_rel = 0; inc_gl = 0;
    if (en && synced != m_level) begin
      m_run++;
      if (m_run == FC) begin
        m_level = !m_level;
        m_run   = 0;
        if (m_level) m_rise = 1;
        else begin m_fall = 1; inc_rel = 1; end
      end
    end else begin
      if (m_run > 0 && en) inc_gl = 1;
      m_run = 0;
    end
    if (clr_cnt) begin m_rel = 0; m_gl = 0; end
    else begin
      if (inc_rel && m_rel < CMAX) m_rel++;
      if (inc_gl && m_gl < CMAX) m_gl++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic compare_model(input string name);
    vectors++;
    if ({level_out, rise_pulse, fall_pulse, release_cnt, glitch_cnt} !==
        {m_level, m_rise, m_fall, CW'(m_rel), CW'(m_gl)}) begin
      miscompares++;
      $display("FAIL %s @%0t: got lvl=%0b rise=%0b fall=%0b rel=%0d gl=%0d, want lvl=%0b rise=%0b fall=%0b rel=%0d gl=%0d",
               name, $time, level_out, rise_pulse, fall_pulse, release_cnt, glitch_cnt,
               m_level, m_rise, m_fall, m_rel, m_gl);
    end
  endtask

  task automatic step_check(input string name);
    tick();
    compare_model(name);
  endtask

  task automatic settle(input logic val, input int n, input string name);
    async_in = val;
    repeat (n) step_check(name);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic    rst_n, async_in, en, clr;
    logic    level, rise, fall;
    logic [CW-1:0] rel, gl;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input logic r, input logic a, input logic e, input logic c,
                         input logic l, input logic ri, input logic f, input int rel, input int gl);
    vec_t v;
    v.rst_n = r; v.async_in = a; v.en = e; v.clr = c;
    v.level = l; v.rise = ri; v.fall = f; v.rel = CW'(rel); v.gl = CW'(gl);
    tbl.push_back(v);
  endtask

  initial begin
    int run_left;
    rst_n = 1'b0; async_in = 1'b0; en = 1'b1; clr_cnt = 1'b0;
    model_reset();

    // Reset held with async_in=1, release, rise at 6th edge, then release path.
    repeat (3) add_vec(0, 1, 1, 0, 0, 0, 0, 0, 0);
    repeat (5) add_vec(1, 1, 1, 0, 0, 0, 0, 0, 0);
    add_vec(1, 1, 1, 0, 1, 1, 0, 0, 0);
    add_vec(1, 1, 1, 0, 1, 0, 0, 0, 0);
    repeat (5) add_vec(1, 0, 1, 0, 1, 0, 0, 0, 0);
    add_vec(1, 0, 1, 0, 0, 0, 1, 1, 0);
    add_vec(1, 0, 1, 0, 0, 0, 0, 1, 0);
    add_vec(1, 0, 1, 1, 0, 0, 0, 0, 0);

    @(negedge clk);
    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n; async_in = tbl[i].async_in;
      en = tbl[i].en; clr_cnt = tbl[i].clr;
      tick();
      vectors++;
      if ({level_out, rise_pulse, fall_pulse, release_cnt, glitch_cnt} !==
          {tbl[i].level, tbl[i].rise, tbl[i].fall, tbl[i].rel, tbl[i].gl}) begin
        miscompares++;
        $display("FAIL table[%0d]: got lvl=%0b rise=%0b fall=%0b rel=%0d gl=%0d, want lvl=%0b rise=%0b fall=%0b rel=%0d gl=%0d",
                 i, level_out, rise_pulse, fall_pulse, release_cnt, glitch_cnt,
                 tbl[i].level, tbl[i].rise, tbl[i].fall, tbl[i].rel, tbl[i].gl);
      end
    end
    clr_cnt = 1'b0;

    // Two-cycle glitches: counted once each, saturating at all-ones.
    for (int r = 0; r < 300; r++) begin
      settle(1'b1, 2, "glitch_hi");
      settle(1'b0, 4, "glitch_lo");
      if (r == 0) chk("glitch_first", glitch_cnt, 1);
    end
    chk("glitch_sat", glitch_cnt, CMAX);
    chk("glitch_level", level_out, 0);
    clr_cnt = 1'b1;
    step_check("glitch_clr");
    clr_cnt = 1'b0;
    chk("glitch_clr_val", glitch_cnt, 0);

    // en dropped mid-QUAL_HIGH: back to ST_LOW, no glitch.
    settle(1'b1, 3, "en_qual");
    en = 1'b0;
    repeat (3) step_check("en_off");
    chk("en_drop_glitch", glitch_cnt, 0);
    chk("en_drop_level", level_out, 0);
    en = 1'b1;
    repeat (4) step_check("en_on");
    chk("en_requal_level", level_out, 1);

    // clr_cnt in the same cycle as fall_pulse.
    settle(1'b0, 8, "fall_a");
    settle(1'b1, 8, "rise_a");
    chk("rel_before_clr", release_cnt, 1);
    settle(1'b0, 5, "fall_b");
    clr_cnt = 1'b1;
    step_check("fall_clr");
    clr_cnt = 1'b0;
    chk("fall_clr_pulse", fall_pulse, 1);
    chk("fall_clr_rel", release_cnt, 0);

    // Reset while in QUAL_LOW with level_out=1.
    settle(1'b0, 3, "pre_rst_lo");
    settle(1'b1, 8, "pre_rst_hi");
    settle(1'b0, 4, "qual_low");
    chk("qual_low_level", level_out, 1);
    rst_n = 1'b0;
    step_check("mid_rst");
    chk("mid_rst_level", level_out, 0);
    chk("mid_rst_fall", fall_pulse, 0);
    chk("mid_rst_rel", release_cnt, 0);
    rst_n = 1'b1;

    // Deassert 4 ns before an edge; level must fall on the 6th edge.
    settle(1'b1, 10, "rv_hi");
    #1 async_in = 1'b0;
    repeat (5) step_check("rv_wait");
    chk("rv_still_high", level_out, 1);
    step_check("rv_fall");
    chk("rv_level", level_out, 0);
    chk("rv_rel", release_cnt, 1);

    // Randomized runs against the model.
    run_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (run_left == 0) begin
        async_in = 1'($urandom_range(0, 1));
        run_left = $urandom_range(1, 9);
      end
      run_left--;
      en      = ($urandom_range(0, 9) != 0);
      clr_cnt = ($urandom_range(0, 49) == 0);
      rst_n   = ($urandom_range(0, 299) != 0);
      step_check("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
